// File: rtl/sma_stream.sv
// Streaming simple-moving-average filter over a power-of-two window of signed samples.
// Registered output with valid strobe, window-filled flag and synchronous flush.
module sma_stream #(
    parameter int DATA_W   = 16,
    parameter int LOG2_WIN = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_valid,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     flush,
    output logic                     y_valid,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_full
);

    localparam int N     = 1 << LOG2_WIN;
    localparam int ACC_W = DATA_W + LOG2_WIN;
    localparam logic [LOG2_WIN:0] FILL_MAX  = (LOG2_WIN + 1)'(N);
    localparam logic [LOG2_WIN:0] FILL_LAST = (LOG2_WIN + 1)'(N - 1);

    logic signed [DATA_W-1:0] buf_mem [N];

    logic [LOG2_WIN-1:0]      ptr_q,     ptr_d;
    logic [LOG2_WIN:0]        fill_q,    fill_d;
    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic signed [DATA_W-1:0] y_q,       y_d;
    logic                     y_valid_q, y_valid_d;
    logic                     y_full_q,  y_full_d;

    logic                     accept;
    logic                     win_full;
    logic signed [DATA_W-1:0] old_sample;
    logic signed [ACC_W-1:0]  old_ext;
    logic signed [ACC_W-1:0]  x_ext;
    logic signed [ACC_W-1:0]  acc_next;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        accept     = x_valid && !flush;
        win_full   = (fill_q == FILL_MAX);
        // Until the window is full the slot under ptr holds stale data and counts as zero.
        old_sample = win_full ? buf_mem[ptr_q] : '0;
        old_ext    = {{LOG2_WIN{old_sample[DATA_W-1]}}, old_sample};
        x_ext      = {{LOG2_WIN{x[DATA_W-1]}}, x};
        acc_next   = acc_q - old_ext + x_ext;

        ptr_d     = ptr_q;
        fill_d    = fill_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        y_full_d  = y_full_q;

        if (flush) begin
            ptr_d    = '0;
            fill_d   = '0;
            acc_d    = '0;
            y_full_d = 1'b0;
        end else if (x_valid) begin
            ptr_d     = ptr_q + 1'b1;
            fill_d    = win_full ? fill_q : fill_q + 1'b1;
            acc_d     = acc_next;
            // Dropping the low LOG2_WIN bits of the signed sum is a flooring divide by N.
            y_d       = acc_next[ACC_W-1:LOG2_WIN];
            y_valid_d = 1'b1;
            y_full_d  = (fill_q >= FILL_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            fill_q    <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_full_q  <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_full_q  <= y_full_d;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; fill_q masks its stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[ptr_q] <= x;
        end
    end

    assign y_valid = y_valid_q;
    assign y       = y_q;
    assign y_full  = y_full_q;

endmodule

// File: tb/tb_sma_stream.sv
// Directed and parameter-sweep checks of sma_stream against hand-computed values
// and a windowed-sum reference model.
module tb_sma_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic               x_valid = 1'b0;
    logic signed [15:0] x       = '0;
    logic               flush   = 1'b0;
    logic               y_valid;
    logic signed [15:0] y;
    logic               y_full;

    logic               sw_valid = 1'b0;
    logic               sw_flush = 1'b0;
    logic signed [7:0]  s1_x = '0;
    logic signed [23:0] s3_x = '0;
    logic signed [15:0] s8_x = '0;
    logic               s1_v, s3_v, s8_v;
    logic               s1_f, s3_f, s8_f;
    logic signed [7:0]  s1_y;
    logic signed [23:0] s3_y;
    logic signed [15:0] s8_y;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sma_stream #(.DATA_W(16), .LOG2_WIN(2)) u_dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .flush(flush),
        .y_valid(y_valid), .y(y), .y_full(y_full));

    sma_stream #(.DATA_W(8), .LOG2_WIN(1)) u_s1 (
        .clk(clk), .rst(rst), .x_valid(sw_valid), .x(s1_x), .flush(sw_flush),
        .y_valid(s1_v), .y(s1_y), .y_full(s1_f));

    sma_stream #(.DATA_W(24), .LOG2_WIN(3)) u_s3 (
        .clk(clk), .rst(rst), .x_valid(sw_valid), .x(s3_x), .flush(sw_flush),
        .y_valid(s3_v), .y(s3_y), .y_full(s3_f));

    sma_stream #(.DATA_W(16), .LOG2_WIN(8)) u_s8 (
        .clk(clk), .rst(rst), .x_valid(sw_valid), .x(s8_x), .flush(sw_flush),
        .y_valid(s8_v), .y(s8_y), .y_full(s8_f));

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic signed [15:0] yy, input logic full);
        check({tag, ".y_valid"}, y_valid, v);
        check({tag, ".y"}, y, yy);
        check({tag, ".y_full"}, y_full, full);
    endtask

    // Present one input for exactly one clock edge, then look just after the edge.
    task automatic step(input logic v, input logic signed [15:0] xv, input logic f);
        x_valid = v;
        x       = xv;
        flush   = f;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        expect_out(tag, 1'b0, 16'sd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic longint win_sum(input longint h[$], input int n);
        longint s = 0;
        for (int i = 0; i < n && i < h.size(); i++) s += h[i];
        return s;
    endfunction

    initial begin
        longint h1[$];
        longint h3[$];
        longint h8[$];

        #2;
        expect_out("por", 1'b0, 16'sd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Warm-up then steady state.
        step(1, 16'sd4, 0);  expect_out("warm1", 1, 16'sd1, 0);
        step(1, 16'sd8, 0);  expect_out("warm2", 1, 16'sd3, 0);
        step(1, 16'sd12, 0); expect_out("warm3", 1, 16'sd6, 0);
        step(1, 16'sd16, 0); expect_out("warm4", 1, 16'sd10, 1);
        step(1, 16'sd20, 0); expect_out("steady", 1, 16'sd14, 1);
        step(0, 16'sd99, 0); expect_out("idle", 0, 16'sd14, 1);

        // Negative samples and floor toward -inf.
        do_reset("rst_neg");
        step(1, -16'sd1, 0); expect_out("neg1", 1, -16'sd1, 0);
        step(1, -16'sd1, 0); expect_out("neg2", 1, -16'sd1, 0);
        step(1, -16'sd1, 0); expect_out("neg3", 1, -16'sd1, 0);
        step(1, -16'sd1, 0); expect_out("neg4", 1, -16'sd1, 1);
        step(1, 16'sd3, 0);  expect_out("neg_pos", 1, 16'sd0, 1);

        // Full-scale positive then negative.
        do_reset("rst_fs");
        step(1, 16'sd32767, 0); expect_out("fsp1", 1, 16'sd8191, 0);
        step(1, 16'sd32767, 0); expect_out("fsp2", 1, 16'sd16383, 0);
        step(1, 16'sd32767, 0); expect_out("fsp3", 1, 16'sd24575, 0);
        step(1, 16'sd32767, 0); expect_out("fsp4", 1, 16'sd32767, 1);
        step(1, -16'sd32768, 0); expect_out("fsn1", 1, 16'sd16383, 1);
        step(1, -16'sd32768, 0); expect_out("fsn2", 1, -16'sd1, 1);
        step(1, -16'sd32768, 0); expect_out("fsn3", 1, -16'sd16385, 1);
        step(1, -16'sd32768, 0); expect_out("fsn4", 1, -16'sd32768, 1);

        // Gapped stream gives the same averages; y holds in the gaps.
        do_reset("rst_gap");
        step(1, 16'sd4, 0);  expect_out("gap1", 1, 16'sd1, 0);
        step(0, 16'sd0, 0);  expect_out("gap1i", 0, 16'sd1, 0);
        step(1, 16'sd8, 0);  expect_out("gap2", 1, 16'sd3, 0);
        step(0, 16'sd0, 0);  expect_out("gap2i", 0, 16'sd3, 0);
        step(1, 16'sd12, 0); expect_out("gap3", 1, 16'sd6, 0);
        step(0, 16'sd0, 0);  expect_out("gap3i", 0, 16'sd6, 0);
        step(1, 16'sd16, 0); expect_out("gap4", 1, 16'sd10, 1);
        step(0, 16'sd0, 0);  expect_out("gap4i", 0, 16'sd10, 1);
        step(1, 16'sd20, 0); expect_out("gap5", 1, 16'sd14, 1);

        // Flush beats x_valid and restarts warm-up.
        do_reset("rst_fl");
        step(1, 16'sd4, 0);   expect_out("fl1", 1, 16'sd1, 0);
        step(1, 16'sd8, 0);   expect_out("fl2", 1, 16'sd3, 0);
        step(1, 16'sd12, 0);  expect_out("fl3", 1, 16'sd6, 0);
        step(1, 16'sd100, 1); expect_out("flush", 0, 16'sd6, 0);
        step(1, 16'sd8, 0);   expect_out("post_fl", 1, 16'sd2, 0);

        // Flush of a full window clears y_full.
        step(1, 16'sd8, 0); step(1, 16'sd8, 0); step(1, 16'sd8, 0);
        expect_out("refill", 1, 16'sd8, 1);
        step(0, 16'sd0, 1); expect_out("flush_full", 0, 16'sd8, 0);

        // Asynchronous reset mid-window, then warm-up restarts.
        step(1, 16'sd4, 0); step(1, 16'sd8, 0); step(1, 16'sd12, 0); step(1, 16'sd16, 0);
        expect_out("pre_rst", 1, 16'sd10, 1);
        #2;
        do_reset("rst_mid");
        step(1, 16'sd8, 0); expect_out("post_rst", 1, 16'sd2, 0);

        // Parameter sweep against the windowed-sum model.
        do_reset("rst_sweep");
        for (int i = 0; i < 700; i++) begin
            sw_valid = ($urandom_range(0, 3) != 0);
            s1_x     = 8'($urandom);
            s3_x     = 24'($urandom);
            s8_x     = 16'($urandom);
            @(posedge clk);
            #1;
            if (sw_valid) begin
                h1.push_front(longint'(s1_x));
                h3.push_front(longint'(s3_x));
                h8.push_front(longint'(s8_x));
                check("s1.y_valid", s1_v, 1'b1);
                check("s1.y", s1_y, win_sum(h1, 2) >>> 1);
                check("s3.y", s3_y, win_sum(h3, 8) >>> 3);
                check("s8.y", s8_y, win_sum(h8, 256) >>> 8);
                check("s8.y_full", s8_f, h8.size() >= 256);
            end else begin
                check("sweep.idle_valid", {s1_v, s3_v, s8_v}, 3'b000);
            end
        end
        sw_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
